upf_pwr_seq: RTL and testbench

//  Parametrised power-mode sequencer for N_DOM switchable power domains; next generation of the single-domain mode_req/mode_ack demo control.

---
 rtl/upf_pwr_seq_if.sv | 32 +++
 rtl/upf_pwr_seq.sv | 209 ++++++++++++++++++++
 tb/tb_upf_pwr_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/upf_pwr_seq_if.sv
// Request/acknowledge and power-control bundle between the system mode
// controller, the power sequencer and the UPF switch/isolation/retention cells.
interface upf_pwr_seq_if #(
  parameter int N_DOM = 2
);
  logic             mode_req;
  logic [N_DOM-1:0] mode;
  logic [N_DOM-1:0] pwr_good;
  logic             mode_ack;
  logic             busy;
  logic             req_drop;
  logic             pg_err;
  logic [N_DOM-1:0] pwr_en;
  logic [N_DOM-1:0] iso_en;
  logic [N_DOM-1:0] ret_save;
  logic [N_DOM-1:0] ret_restore;
  logic [N_DOM-1:0] dom_state;

  // Sequencer side
  modport slave (
    input  mode_req, mode, pwr_good,
    output mode_ack, busy, req_drop, pg_err,
    output pwr_en, iso_en, ret_save, ret_restore, dom_state
  );

  // Environment side: mode controller plus power switches
  modport master (
    output mode_req, mode, pwr_good,
    input  mode_ack, busy, req_drop, pg_err,
    input  pwr_en, iso_en, ret_save, ret_restore, dom_state
  );
endinterface

// File: rtl/upf_pwr_seq.sv
// Power-mode sequencer for N_DOM switchable domains.
// A request carries a target on/off vector; domains going down are saved,
// isolated and switched off first, then domains going up are switched on,
// checked for power-good, restored and de-isolated. Power-good waits are
// bounded and a timeout raises the sticky pg_err flag.
module upf_pwr_seq #(
  parameter int N_DOM       = 2,
  parameter int SAVE_CYCLES = 2,
  parameter int ISO_CYCLES  = 1,
  parameter int PG_TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  upf_pwr_seq_if.slave  bus
);

  localparam int MAXP_A = (SAVE_CYCLES > ISO_CYCLES) ? SAVE_CYCLES : ISO_CYCLES;
  localparam int MAXP   = (MAXP_A > PG_TIMEOUT) ? MAXP_A : PG_TIMEOUT;
  localparam int CW     = $clog2(MAXP) + 1;

  // Counter values on the last cycle of each timed state
  localparam logic [CW-1:0] SAVE_LAST = CW'(SAVE_CYCLES - 1);
  localparam logic [CW-1:0] ISO_LAST  = CW'(ISO_CYCLES - 1);
  localparam logic [CW-1:0] PG_LAST   = CW'(PG_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SAVE,
    S_ISO,
    S_OFF,
    S_ON,
    S_WAIT_PG,
    S_RESTORE,
    S_UNISO,
    S_ACK
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [N_DOM-1:0] r_dn;
  logic [N_DOM-1:0] r_up;
  logic [N_DOM-1:0] r_pwr_en;
  logic [N_DOM-1:0] r_iso_en;
  logic [N_DOM-1:0] r_ret_save;
  logic [N_DOM-1:0] r_ret_restore;
  logic [N_DOM-1:0] r_dom_state;
  logic             r_mode_ack;
  logic             r_busy;
  logic             r_req_drop;
  logic             r_pg_err;

  logic [N_DOM-1:0] w_dn;
  logic [N_DOM-1:0] w_up;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_off_done;
  logic             w_up_good;

  // Domains to switch off / on, derived from the committed state
  assign w_dn = r_dom_state & ~bus.mode;
  assign w_up = ~r_dom_state & bus.mode;

  // Saturating increment: the counter never wraps even if a state lingers
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  // Power-good status of the domains in flight
  assign w_off_done = ((bus.pwr_good & r_dn) == '0);
  assign w_up_good  = ((bus.pwr_good & r_up) == r_up);

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_dn          <= '0;
      r_up          <= '0;
      r_pwr_en      <= '1;
      r_iso_en      <= '0;
      r_ret_save    <= '0;
      r_ret_restore <= '0;
      r_dom_state   <= '1;
      r_mode_ack    <= 1'b0;
      r_busy        <= 1'b0;
      r_req_drop    <= 1'b0;
      r_pg_err      <= 1'b0;
    end else begin
      r_mode_ack <= 1'b0;
      r_req_drop <= bus.mode_req && (r_state != S_IDLE);
      r_cnt      <= w_cnt_inc;

      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.mode_req) begin
            r_dn     <= w_dn;
            r_up     <= w_up;
            r_pg_err <= 1'b0;
            r_busy   <= 1'b1;
            if (w_dn != '0) begin
              r_state    <= S_SAVE;
              r_ret_save <= w_dn;
            end else if (w_up != '0) begin
              r_state  <= S_ON;
              r_pwr_en <= r_pwr_en | w_up;
            end else begin
              r_state    <= S_ACK;
              r_mode_ack <= 1'b1;
            end
          end
        end

        S_SAVE: begin
          if (r_cnt == SAVE_LAST) begin
            r_state    <= S_ISO;
            r_cnt      <= '0;
            r_ret_save <= '0;
            r_iso_en   <= r_iso_en | r_dn;
          end
        end

        S_ISO: begin
          if (r_cnt == ISO_LAST) begin
            r_state  <= S_OFF;
            r_cnt    <= '0;
            r_pwr_en <= r_pwr_en & ~r_dn;
          end
        end

        // A domain that never reports power loss is still treated as off
        S_OFF: begin
          if (w_off_done || (r_cnt == PG_LAST)) begin
            r_cnt       <= '0;
            r_dom_state <= r_dom_state & ~r_dn;
            if (!w_off_done) begin
              r_pg_err <= 1'b1;
            end
            if (r_up != '0) begin
              r_state  <= S_ON;
              r_pwr_en <= r_pwr_en | r_up;
            end else begin
              r_state    <= S_ACK;
              r_mode_ack <= 1'b1;
            end
          end
        end

        S_ON: begin
          r_state <= S_WAIT_PG;
          r_cnt   <= '0;
        end

        // On timeout the switches are turned back off and clamps stay on
        S_WAIT_PG: begin
          if (w_up_good) begin
            r_state       <= S_RESTORE;
            r_cnt         <= '0;
            r_ret_restore <= r_up;
          end else if (r_cnt == PG_LAST) begin
            r_state    <= S_ACK;
            r_cnt      <= '0;
            r_pg_err   <= 1'b1;
            r_pwr_en   <= r_pwr_en & ~r_up;
            r_mode_ack <= 1'b1;
          end
        end

        S_RESTORE: begin
          if (r_cnt == SAVE_LAST) begin
            r_state       <= S_UNISO;
            r_cnt         <= '0;
            r_ret_restore <= '0;
            r_iso_en      <= r_iso_en & ~r_up;
            r_dom_state   <= r_dom_state | r_up;
          end
        end

        S_UNISO: begin
          r_state    <= S_ACK;
          r_cnt      <= '0;
          r_mode_ack <= 1'b1;
        end

        // Requests arriving here are dropped; acceptance resumes in IDLE
        S_ACK: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mode_ack    = r_mode_ack;
  assign bus.busy        = r_busy;
  assign bus.req_drop    = r_req_drop;
  assign bus.pg_err      = r_pg_err;
  assign bus.pwr_en      = r_pwr_en;
  assign bus.iso_en      = r_iso_en;
  assign bus.ret_save    = r_ret_save;
  assign bus.ret_restore = r_ret_restore;
  assign bus.dom_state   = r_dom_state;

endmodule

// File: tb/tb_upf_pwr_seq.sv
// Directed bench for the power sequencer: two domains, power-good modelled
// as pwr_en delayed by one clock, with a per-domain stuck-at-0 override.
module tb_upf_pwr_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] pg_reg = 2'b11;
  logic [1:0] pg_stuck = 2'b00;
  int         n_checks = 0;
  int         n_pass = 0;

  upf_pwr_seq_if #(.N_DOM(2)) bus ();

  upf_pwr_seq #(
    .N_DOM(2),
    .SAVE_CYCLES(2),
    .ISO_CYCLES(1),
    .PG_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Switch model: power-good follows the enable one clock late
  always @(posedge clk) pg_reg <= bus.pwr_en;
  assign bus.pwr_good = pg_reg & ~pg_stuck;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    bus.mode_req = 1'b0;
    bus.mode     = 2'b11;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // 1: reset state
    chk("rst_pwr_en", 32'(bus.pwr_en), 32'h3);
    chk("rst_iso_en", 32'(bus.iso_en), 32'h0);
    chk("rst_dom",    32'(bus.dom_state), 32'h3);
    chk("rst_busy",   32'(bus.busy), 32'h0);
    chk("rst_ack",    32'(bus.mode_ack), 32'h0);
    chk("rst_pgerr",  32'(bus.pg_err), 32'h0);
    $display("T1 reset released: pwr_en=%b dom=%b", bus.pwr_en, bus.dom_state);

    // 2: switch domain 0 off
    bus.mode = 2'b10; bus.mode_req = 1'b1;
    tick();                                   // accept edge
    bus.mode_req = 1'b0;
    chk("t2_busy",      32'(bus.busy), 32'h1);
    chk("t2_save_e0",   32'(bus.ret_save), 32'h1);
    tick();
    chk("t2_save_e1",   32'(bus.ret_save), 32'h1);
    tick();
    chk("t2_save_e2",   32'(bus.ret_save), 32'h0);
    chk("t2_iso_e2",    32'(bus.iso_en), 32'h1);
    chk("t2_pwr_e2",    32'(bus.pwr_en), 32'h3);
    tick();
    chk("t2_pwr_e3",    32'(bus.pwr_en), 32'h2);
    tick();
    chk("t2_ack_e4",    32'(bus.mode_ack), 32'h0);
    chk("t2_dom_e4",    32'(bus.dom_state), 32'h3);
    tick();
    chk("t2_ack_e5",    32'(bus.mode_ack), 32'h1);
    chk("t2_dom_e5",    32'(bus.dom_state), 32'h2);
    tick();
    chk("t2_ack_e6",    32'(bus.mode_ack), 32'h0);
    chk("t2_busy_e6",   32'(bus.busy), 32'h0);
    $display("T2 domain0 off: dom=%b iso=%b pwr_en=%b", bus.dom_state, bus.iso_en, bus.pwr_en);

    // 3: switch domain 0 back on
    bus.mode = 2'b11; bus.mode_req = 1'b1;
    tick();
    bus.mode_req = 1'b0;
    chk("t3_pwr_e0",    32'(bus.pwr_en), 32'h3);
    tick();
    chk("t3_rest_e1",   32'(bus.ret_restore), 32'h0);
    tick();
    chk("t3_rest_e2",   32'(bus.ret_restore), 32'h1);
    tick();
    chk("t3_rest_e3",   32'(bus.ret_restore), 32'h1);
    chk("t3_iso_e3",    32'(bus.iso_en), 32'h1);
    tick();
    chk("t3_rest_e4",   32'(bus.ret_restore), 32'h0);
    chk("t3_iso_e4",    32'(bus.iso_en), 32'h0);
    chk("t3_dom_e4",    32'(bus.dom_state), 32'h3);
    tick();
    chk("t3_ack_e5",    32'(bus.mode_ack), 32'h1);
    tick();
    chk("t3_ack_e6",    32'(bus.mode_ack), 32'h0);
    $display("T3 domain0 on: dom=%b iso=%b pwr_en=%b", bus.dom_state, bus.iso_en, bus.pwr_en);

    // 4: power-up timeout (domain 0 power-good stuck low)
    bus.mode = 2'b10; bus.mode_req = 1'b1;
    tick();
    bus.mode_req = 1'b0;
    repeat (6) tick();
    chk("t4_pre_dom",   32'(bus.dom_state), 32'h2);
    pg_stuck = 2'b01;
    bus.mode = 2'b11; bus.mode_req = 1'b1;
    tick();
    bus.mode_req = 1'b0;
    repeat (16) tick();
    chk("t4_pgerr_e16", 32'(bus.pg_err), 32'h0);
    chk("t4_pwr_e16",   32'(bus.pwr_en), 32'h3);
    tick();
    chk("t4_pgerr_e17", 32'(bus.pg_err), 32'h1);
    chk("t4_pwr_e17",   32'(bus.pwr_en), 32'h2);
    chk("t4_iso_e17",   32'(bus.iso_en), 32'h1);
    chk("t4_ack_e17",   32'(bus.mode_ack), 32'h1);
    chk("t4_dom_e17",   32'(bus.dom_state), 32'h2);
    tick();
    chk("t4_busy_e18",  32'(bus.busy), 32'h0);
    chk("t4_sticky",    32'(bus.pg_err), 32'h1);
    pg_stuck = 2'b00;
    $display("T4 power-up timeout: pg_err=%b dom=%b pwr_en=%b", bus.pg_err, bus.dom_state, bus.pwr_en);

    // 5: swap domains 10 -> 01, down must finish before up starts
    bus.mode = 2'b01; bus.mode_req = 1'b1;
    tick();
    bus.mode_req = 1'b0;
    chk("t5_pgerr_clr", 32'(bus.pg_err), 32'h0);
    chk("t5_save_e0",   32'(bus.ret_save), 32'h2);
    tick(); tick();
    chk("t5_iso_e2",    32'(bus.iso_en), 32'h3);
    tick();
    chk("t5_pwr_e3",    32'(bus.pwr_en), 32'h0);
    tick();
    chk("t5_pwr_e4",    32'(bus.pwr_en), 32'h0);
    chk("t5_dom_e4",    32'(bus.dom_state), 32'h2);
    tick();
    chk("t5_pwr_e5",    32'(bus.pwr_en), 32'h1);
    chk("t5_dom_e5",    32'(bus.dom_state), 32'h0);
    tick(); tick();
    chk("t5_rest_e7",   32'(bus.ret_restore), 32'h1);
    tick(); tick();
    chk("t5_iso_e9",    32'(bus.iso_en), 32'h2);
    chk("t5_dom_e9",    32'(bus.dom_state), 32'h1);
    tick();
    chk("t5_ack_e10",   32'(bus.mode_ack), 32'h1);
    tick();
    chk("t5_busy_e11",  32'(bus.busy), 32'h0);
    // no-op request: ack one cycle after accept
    bus.mode = 2'b01; bus.mode_req = 1'b1;
    tick();
    bus.mode_req = 1'b0;
    chk("t5_noop_ack",  32'(bus.mode_ack), 32'h1);
    chk("t5_noop_busy", 32'(bus.busy), 32'h1);
    tick();
    chk("t5_noop_ack1", 32'(bus.mode_ack), 32'h0);
    chk("t5_noop_dom",  32'(bus.dom_state), 32'h1);
    $display("T5 swap + no-op: dom=%b iso=%b pwr_en=%b", bus.dom_state, bus.iso_en, bus.pwr_en);

    // 6: request during SAVE is dropped; reset during OFF
    bus.mode = 2'b00; bus.mode_req = 1'b1;
    tick();
    chk("t6_save_e0",   32'(bus.ret_save), 32'h1);
    bus.mode = 2'b10;                         // held request with a new mode
    tick();
    bus.mode_req = 1'b0;
    chk("t6_drop_e1",   32'(bus.req_drop), 32'h1);
    tick();
    chk("t6_drop_e2",   32'(bus.req_drop), 32'h0);
    chk("t6_iso_e2",    32'(bus.iso_en), 32'h3);
    tick();
    chk("t6_pwr_e3",    32'(bus.pwr_en), 32'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_pwr",   32'(bus.pwr_en), 32'h3);
    chk("t6_rst_iso",   32'(bus.iso_en), 32'h0);
    chk("t6_rst_dom",   32'(bus.dom_state), 32'h3);
    chk("t6_rst_busy",  32'(bus.busy), 32'h0);
    chk("t6_rst_save",  32'(bus.ret_save), 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("t6_no_ack",    32'(bus.mode_ack), 32'h0);
    chk("t6_idle",      32'(bus.busy), 32'h0);
    $display("T6 drop + reset: pwr_en=%b iso=%b dom=%b", bus.pwr_en, bus.iso_en, bus.dom_state);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
